sm_mem_arbiter: RTL and testbench
=================================

Name: sm_mem_arbiter

Overview:
- Two-master, one-slave arbiter for the valid/ready data-memory port.
- Sits directly upstream of the delayed memory (sm_ram_busy / sm_ram_fast) and lets the instruction-fetch port (port 0) and the load/store port (port 1) share one memory instance.
- Serialises requests, holds the granted request stable for the whole transaction, and routes the completion strobe and read data back to the owner.

Parameters:
- RR, 1, arbitration mode: 1 = round-robin between ports, 0 = fixed priority (port 1 always wins ties).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- s0_valid  in  1  port 0 request; held high until s0_ready
- s0_we  in  1  port 0 write enable
- s0_a  in  32  port 0 address
- s0_wd  in  32  port 0 write data
- s0_ready  out  1  port 0 completion strobe, one cycle
- s0_rd  out  32  port 0 read data, valid when s0_ready
- s1_valid, s1_we, s1_a, s1_wd, s1_ready, s1_rd  same as port 0, for port 1
- m_valid  out  1  request to memory
- m_we  out  1  write enable to memory
- m_a  out  32  address to memory
- m_wd  out  32  write data to memory
- m_ready  in  1  memory ready
- m_rd  in  32  memory read data

Behaviour:
- FSM states: S_IDLE (no transaction), S_WAIT (request accepted, awaiting completion). Registers: state, grant (1 bit), last (1 bit).
- Reset (rst=1 at a clock edge): state=S_IDLE, grant=0, last=1. While rst=1, m_valid=0, s0_ready=s1_ready=0, s0_rd=s1_rd=0.
- Selection (combinational, S_IDLE only), sel:
  - If only one port is valid, sel = that port.
  - If both are valid and RR=1, sel = ~last. If RR=0, sel = 1.
- S_IDLE:
  - m_valid = s0_valid|s1_valid.
  - m_we/m_a/m_wd = fields of port sel.
  - Acceptance = m_valid & m_ready. On acceptance: grant<=sel, last<=sel, state<=S_WAIT.
  - Without acceptance, stay in S_IDLE; nothing is latched.
- S_WAIT:
  - m_valid=0.
  - m_we/m_a/m_wd = fields of port grant. The master holds them stable, so the mux output is stable.
  - Completion = first cycle in S_WAIT with m_ready=1. In that cycle: s<grant>_ready=1, s<grant>_rd=m_rd, state<=S_IDLE.
- Read-data gating: sN_rd = m_rd only in port N's completion cycle, else 0. For writes, sN_rd is don't-care but still gated to 0 outside completion.
- No new request is issued in the completion cycle (a busy memory ignores valid in its READY state). The next acceptance is earliest in the following cycle.
- Latency: acceptance at cycle T, completion at T+1 for sm_ram_fast, T+DELAY-1 for sm_ram_busy. Minimum one idle cycle between transactions.
- The non-granted port keeps s_ready=0 for any number of cycles. There is no drop or timeout, and its request stays pending.
- If a master drops valid while in S_WAIT (a protocol violation), the transaction still completes and the strobe is still issued.
- Simultaneous events:
  - A new valid on the other port during completion waits for S_IDLE.
  - Under RR=1 with both ports continuously valid, grants strictly alternate 0,1,0,1…
- Reset mid-transaction: returns to S_IDLE immediately, with no strobe for the aborted request. The memory shares the same reset, so its FSM also returns to idle.

Test Plan:
- Single read, sm_ram_busy DELAY=4, mem[5]=0x1234: s0_valid=1, s0_a=20 -> m_valid=1 in cycle 0; s0_ready=1 and s0_rd=0x00001234 in cycle 3 only; s1_ready=0 throughout.
- Write then read on port 1: s1_we=1, s1_a=8, s1_wd=0xDEADBEEF, then read a=8 -> s1_rd=0xDEADBEEF. Port 0 gets no strobe, s0_rd=0.
- RR=1, both ports valid continuously, 6 transactions -> grant order 0,1,0,1,0,1 (first grant port 0 after reset); each port sees exactly 3 strobes.
- RR=0, both valid -> port 1 served repeatedly; port 0 served only after s1_valid deasserts; s0_ready stays 0 until then.
- sm_ram_fast: back-to-back port 0 reads -> one transaction per 2 cycles; m_a stable across the accept and completion cycles.
- Assert rst for 1 cycle in S_WAIT mid DELAY=4 read -> no s0_ready for that request; m_valid=0 during rst; next request completes normally with correct data.

Source files
------------

// File: rtl/sm_mem_arbiter.sv
// rtl/sm_mem_arbiter.sv - two-master, one-slave arbiter for the valid/ready data-memory port
//
// Lets the instruction-fetch port (s0) and the load/store port (s1) share one
// delayed memory. One transaction at a time: a request is accepted in S_IDLE,
// the owning port is remembered in grant, and the completion strobe plus read
// data are steered back to that owner only.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   s0_valid/we/a/wd -> s0_ready/rd   port 0 request and completion
//   s1_valid/we/a/wd -> s1_ready/rd   port 1 request and completion
//   m_valid/we/a/wd  -> m_ready/rd    request to and response from memory
//
// RR = 1 alternates between ports on contention, RR = 0 always favours port 1.

module sm_mem_arbiter #(
    parameter int unsigned RR = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_valid,
    input  logic        s0_we,
    input  logic [31:0] s0_a,
    input  logic [31:0] s0_wd,
    output logic        s0_ready,
    output logic [31:0] s0_rd,
    input  logic        s1_valid,
    input  logic        s1_we,
    input  logic [31:0] s1_a,
    input  logic [31:0] s1_wd,
    output logic        s1_ready,
    output logic [31:0] s1_rd,
    output logic        m_valid,
    output logic        m_we,
    output logic [31:0] m_a,
    output logic [31:0] m_wd,
    input  logic        m_ready,
    input  logic [31:0] m_rd
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   grant;
    logic   grant_nxt;
    logic   last;
    logic   last_nxt;
    logic   sel;
    logic   src;
    logic   req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            grant <= 1'b0;
            // last starts at 1 so the first contended round-robin grant goes to port 0
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

    // Port chosen for a new request; only meaningful in S_IDLE.
    always_comb begin
        if (s0_valid && s1_valid) begin
            sel = (RR != 0) ? ~last : 1'b1;
        end else begin
            sel = s1_valid;
        end
    end

    // While a transaction is outstanding the bus follows the owner; the master
    // holds its fields stable, so the memory sees an unchanging request.
    assign src  = (state == S_IDLE) ? sel : grant;
    assign m_we = src ? s1_we : s0_we;
    assign m_a  = src ? s1_a  : s0_a;
    assign m_wd = src ? s1_wd : s0_wd;
    assign req  = s0_valid | s1_valid;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        m_valid   = 1'b0;
        s0_ready  = 1'b0;
        s1_ready  = 1'b0;
        s0_rd     = 32'd0;
        s1_rd     = 32'd0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    m_valid = req;
                    if (req && m_ready) begin
                        grant_nxt = sel;
                        last_nxt  = sel;
                        state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // First ready after acceptance is the completion; no new
                    // request is presented in this cycle.
                    if (m_ready) begin
                        state_nxt = S_IDLE;
                        if (grant) begin
                            s1_ready = 1'b1;
                            s1_rd    = m_rd;
                        end else begin
                            s0_ready = 1'b1;
                            s0_rd    = m_rd;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_mem_arbiter.sv
// tb/tb_sm_mem_arbiter.sv - self-checking bench for sm_mem_arbiter with a delayed-memory model

module tb_sm_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        act = 1'b0;   // 0: round-robin instance live, 1: fixed-priority instance live

    always #5 clk = ~clk;

    // master-side request state
    logic [1:0]  pv  = 2'b00;
    logic [1:0]  pwe = 2'b00;
    logic [31:0] pa [2];
    logic [31:0] pwd[2];
    bit          hold[2];
    bit          autop[2];

    logic        m_ready = 1'b1;
    logic [31:0] m_rd = 32'd0;

    logic        s0_valid, s0_we, s1_valid, s1_we;
    logic [31:0] s0_a, s0_wd, s1_a, s1_wd;
    assign s0_valid = pv[0];
    assign s0_we    = pwe[0];
    assign s0_a     = pa[0];
    assign s0_wd    = pwd[0];
    assign s1_valid = pv[1];
    assign s1_we    = pwe[1];
    assign s1_a     = pa[1];
    assign s1_wd    = pwd[1];

    logic        r_s0_ready, r_s1_ready, r_m_valid, r_m_we;
    logic [31:0] r_s0_rd, r_s1_rd, r_m_a, r_m_wd;
    logic        f_s0_ready, f_s1_ready, f_m_valid, f_m_we;
    logic [31:0] f_s0_rd, f_s1_rd, f_m_a, f_m_wd;

    sm_mem_arbiter #(.RR(1)) dut_rr (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_we(s0_we), .s0_a(s0_a), .s0_wd(s0_wd),
        .s0_ready(r_s0_ready), .s0_rd(r_s0_rd),
        .s1_valid(s1_valid), .s1_we(s1_we), .s1_a(s1_a), .s1_wd(s1_wd),
        .s1_ready(r_s1_ready), .s1_rd(r_s1_rd),
        .m_valid(r_m_valid), .m_we(r_m_we), .m_a(r_m_a), .m_wd(r_m_wd),
        .m_ready(m_ready), .m_rd(m_rd)
    );

    sm_mem_arbiter #(.RR(0)) dut_fp (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_we(s0_we), .s0_a(s0_a), .s0_wd(s0_wd),
        .s0_ready(f_s0_ready), .s0_rd(f_s0_rd),
        .s1_valid(s1_valid), .s1_we(s1_we), .s1_a(s1_a), .s1_wd(s1_wd),
        .s1_ready(f_s1_ready), .s1_rd(f_s1_rd),
        .m_valid(f_m_valid), .m_we(f_m_we), .m_a(f_m_a), .m_wd(f_m_wd),
        .m_ready(m_ready), .m_rd(m_rd)
    );

    logic        c_s0_ready, c_s1_ready, c_m_valid, c_m_we;
    logic [31:0] c_s0_rd, c_s1_rd, c_m_a, c_m_wd;
    assign c_s0_ready = act ? f_s0_ready : r_s0_ready;
    assign c_s1_ready = act ? f_s1_ready : r_s1_ready;
    assign c_s0_rd    = act ? f_s0_rd    : r_s0_rd;
    assign c_s1_rd    = act ? f_s1_rd    : r_s1_rd;
    assign c_m_valid  = act ? f_m_valid  : r_m_valid;
    assign c_m_we     = act ? f_m_we     : r_m_we;
    assign c_m_a      = act ? f_m_a      : r_m_a;
    assign c_m_wd     = act ? f_m_wd     : r_m_wd;

    // delayed memory: 0 idle (ready=1), 1 busy (ready=0), 2 completion (ready=1)
    logic [31:0] mem[64];
    int          mstate = 0;
    int          mrem = 0;
    logic [31:0] ma = 32'd0;
    int          mem_delay = 3;
    bit          rand_delay = 1'b0;

    // reference model state
    int          own = -1;
    bit          last_m = 1'b1;
    logic [31:0] shadow[64];
    bit          ewe;
    logic [31:0] ea, ewd;

    // observations shared with the stimulus side
    bit          acc_seen;
    bit          strb[2];
    logic [31:0] srd[2];
    int          cyc = 0;
    int          scnt[2];
    int          sq[$];

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, got, exp);
    endtask

    always @(negedge clk) begin
        logic        e_mv, e_r0, e_r1, e_we;
        logic [31:0] e_rd0, e_rd1, e_a, e_wd;
        bit          bus;
        int          sel;
        cyc++;
        strb[0] = c_s0_ready;
        strb[1] = c_s1_ready;
        srd[0]  = c_s0_rd;
        srd[1]  = c_s1_rd;
        if (c_s0_ready) begin scnt[0]++; sq.push_back(0); end
        if (c_s1_ready) begin scnt[1]++; sq.push_back(1); end
        acc_seen = c_m_valid && m_ready && (mstate == 0);

        e_mv = 0; e_r0 = 0; e_r1 = 0; e_rd0 = 0; e_rd1 = 0;
        e_we = 0; e_a = 0; e_wd = 0; bus = 0; sel = 0;
        if (rst) begin
            own = -1;
            last_m = 1'b1;
        end else if (own < 0) begin
            if (pv[0] || pv[1]) begin
                if (pv[0] && pv[1]) sel = (act == 1'b0) ? (last_m ? 0 : 1) : 1;
                else sel = pv[1] ? 1 : 0;
                e_mv = 1; bus = 1;
                e_we = pwe[sel]; e_a = pa[sel]; e_wd = pwd[sel];
                if (m_ready) begin
                    own = sel;
                    last_m = (sel == 1);
                    ewe = pwe[sel]; ea = pa[sel]; ewd = pwd[sel];
                    if (ewe) shadow[ea[7:2]] = ewd;
                end
            end
        end else begin
            bus = 1; e_we = ewe; e_a = ea; e_wd = ewd;
            if (m_ready) begin
                if (own == 0) begin e_r0 = 1; e_rd0 = shadow[ea[7:2]]; end
                else begin e_r1 = 1; e_rd1 = shadow[ea[7:2]]; end
                own = -1;
            end
        end
        chk("m_valid", c_m_valid, e_mv);
        chk("s0_ready", c_s0_ready, e_r0);
        chk("s1_ready", c_s1_ready, e_r1);
        chk("s0_rd", c_s0_rd, e_rd0);
        chk("s1_rd", c_s1_rd, e_rd1);
        if (bus) begin
            chk("m_we", c_m_we, e_we);
            chk("m_a", c_m_a, e_a);
            chk("m_wd", c_m_wd, e_wd);
        end
    end

    task automatic new_req(input int p);
        pv[p]  = 1'b1;
        pwe[p] = 1'($urandom_range(0, 1));
        pa[p]  = 32'($urandom_range(0, 63)) << 2;
        pwd[p] = $urandom;
    endtask

    task automatic env_update();
        int d;
        if (rst) begin
            mstate = 0; m_ready = 1'b1; m_rd = $urandom;
        end else begin
            if (mstate == 2) begin
                mstate = 0; m_ready = 1'b1; m_rd = $urandom;
            end else if (mstate == 0 && acc_seen) begin
                ma = c_m_a;
                if (c_m_we) mem[c_m_a[7:2]] = c_m_wd;
                d = rand_delay ? int'($urandom_range(1, 4)) : mem_delay;
                mstate = 1; mrem = d;
            end
            if (mstate == 1) begin
                mrem--;
                if (mrem == 0) begin
                    mstate = 2; m_ready = 1'b1; m_rd = mem[ma[7:2]];
                end else begin
                    m_ready = 1'b0; m_rd = $urandom;
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (strb[p]) begin
                if (hold[p]) new_req(p);
                else pv[p] = 1'b0;
            end else if (!pv[p] && (hold[p] || (autop[p] && $urandom_range(0, 2) == 0))) begin
                new_req(p);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        env_update();
    endtask

    task automatic do_reset();
        pv = 2'b00; hold[0] = 0; hold[1] = 0; autop[0] = 0; autop[1] = 0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        sq.delete();
    endtask

    task automatic xfer(input int p, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd);
        pv[p] = 1'b1; pwe[p] = we; pa[p] = a; pwd[p] = wd;
        lat = -1; rd = 32'd0;
        for (int n = 0; n < 40 && lat < 0; n++) begin
            @(negedge clk);
            #1;
            if (strb[p]) begin lat = n; rd = srd[p]; end
            step();
        end
    endtask

    initial begin
        int          lat, c0, c1, ones, found;
        logic [31:0] rd;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            shadow[i] = mem[i];
        end
        for (int p = 0; p < 2; p++) begin
            pa[p] = 0; pwd[p] = 0; hold[p] = 0; autop[p] = 0; scnt[p] = 0; strb[p] = 0; srd[p] = 0;
        end

        // single read through DELAY=4 memory
        act = 1'b0;
        do_reset();
        mem_delay = 3; rand_delay = 0;
        mem[5] = 32'h1234; shadow[5] = 32'h1234;
        c1 = scnt[1];
        xfer(0, 1'b0, 32'd20, 32'd0, lat, rd);
        chk("read_latency", 32'(lat), 32'd3);
        chk("read_data", rd, 32'h0000_1234);
        chk("read_no_s1_strobe", 32'(scnt[1] - c1), 32'd0);

        // write then read on port 1
        c0 = scnt[0];
        xfer(1, 1'b1, 32'd8, 32'hDEAD_BEEF, lat, rd);
        chk("write_latency", 32'(lat), 32'd3);
        step();
        xfer(1, 1'b0, 32'd8, 32'd0, lat, rd);
        chk("write_read_data", rd, 32'hDEAD_BEEF);
        chk("wr_no_s0_strobe", 32'(scnt[0] - c0), 32'd0);

        // round-robin, both ports continuously valid
        do_reset();
        rand_delay = 1;
        hold[0] = 1; hold[1] = 1; new_req(0); new_req(1);
        for (int n = 0; n < 200 && sq.size() < 6; n++) step();
        chk("rr_six_grants", 32'(sq.size() >= 6), 32'd1);
        ones = 0;
        for (int i = 0; i < 6 && i < sq.size(); i++) begin
            chk("rr_order", 32'(sq[i]), 32'(i % 2));
            ones += sq[i];
        end
        chk("rr_port1_count", 32'(ones), 32'd3);
        hold[0] = 0; hold[1] = 0;
        repeat (30) step();

        // fixed priority: port 1 wins until it lets go
        act = 1'b1;
        do_reset();
        hold[0] = 1; hold[1] = 1; new_req(0); new_req(1);
        for (int n = 0; n < 200 && sq.size() < 4; n++) step();
        chk("fp_four_grants", 32'(sq.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < sq.size(); i++) chk("fp_port1_wins", 32'(sq[i]), 32'd1);
        chk("fp_port0_starved", 32'(scnt[0] - 0 >= 0 && sq.size() > 0 && sq[0] == 1), 32'd1);
        hold[1] = 0;
        found = 0;
        for (int n = 0; n < 60 && !found; n++) begin
            step();
            for (int i = 0; i < sq.size(); i++) if (sq[i] == 0) found = 1;
        end
        chk("fp_port0_served", 32'(found), 32'd1);
        chk("fp_port0_last", 32'(sq[sq.size() - 1]), 32'd0);
        hold[0] = 0;
        repeat (30) step();

        // fast memory, back-to-back port 0 reads
        act = 1'b0;
        do_reset();
        rand_delay = 0; mem_delay = 1;
        hold[0] = 1; new_req(0);
        c0 = scnt[0];
        repeat (10) step();
        chk("fast_b2b_count", 32'(scnt[0] - c0), 32'd5);
        hold[0] = 0;
        repeat (10) step();

        // reset in the middle of a DELAY=4 read
        do_reset();
        mem_delay = 3;
        mem[5] = 32'h1234; shadow[5] = 32'h1234;
        c0 = scnt[0];
        pv[0] = 1'b1; pwe[0] = 1'b0; pa[0] = 32'd20; pwd[0] = 32'd0;
        step();
        step();
        rst = 1'b1; pv[0] = 1'b0;
        step();
        rst = 1'b0;
        repeat (5) step();
        chk("abort_no_strobe", 32'(scnt[0] - c0), 32'd0);
        xfer(0, 1'b0, 32'd20, 32'd0, lat, rd);
        chk("post_reset_latency", 32'(lat), 32'd3);
        chk("post_reset_data", rd, 32'h0000_1234);

        // randomized traffic in both modes
        for (int ph = 0; ph < 2; ph++) begin
            act = ph[0];
            do_reset();
            rand_delay = 1;
            autop[0] = 1; autop[1] = 1;
            repeat (1500) step();
            autop[0] = 0; autop[1] = 0;
            repeat (30) step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
